// File: rtl/frame_commit_buffer.sv
// frame_commit_buffer: speculative frame store with commit/rewind.
// Words are released downstream only after their frame checks good.
module frame_commit_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [WIDTH-1:0] axiid,
    input  logic             done,
    input  logic             kill,
    input  logic             axiir,
    output logic             axiov,
    output logic [WIDTH-1:0] axiod,
    output logic             axiol,
    output logic [15:0]      frames_ok,
    output logic [15:0]      frames_bad,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // storage: {last, data}
    logic [WIDTH:0]   mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             frame_ovf_q, frame_ovf_d;
    logic             done_q;
    logic             overflow_q, overflow_d;
    logic [15:0]      ok_q, ok_d;
    logic [15:0]      bad_q, bad_d;

    // fetch stage (RAM output) and output skid register
    logic             f_v_q, f_v_d;
    logic [WIDTH:0]   f_q;
    logic             o_v_q, o_v_d;
    logic [WIDTH:0]   o_q;

    logic             we;
    logic [WIDTH:0]   wdata;
    logic [PW-1:0]    occ;
    logic             full;
    logic             done_rise;
    logic             good;

    logic             avail;
    logic             pop;
    logic             rd_en;
    logic             o_load;

    assign occ       = wr_ptr_q - rd_ptr_q;
    assign full      = (occ == FULL_CNT);
    assign done_rise = done & ~done_q;
    assign good      = hold_valid_q & ~kill & ~frame_ovf_q & ~full;

    // write side: hold register, speculative writes, commit or rewind
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        frame_ovf_d  = frame_ovf_q;
        overflow_d   = overflow_q;
        ok_d         = ok_q;
        bad_d        = bad_q;
        we           = 1'b0;
        wdata        = '0;
        if (done_rise) begin
            if (good) begin
                we           = 1'b1;
                wdata        = {1'b1, hold_q};
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                commit_ptr_d = wr_ptr_q + PTR_ONE;
                ok_d         = ok_q + 16'd1;
            end else if (hold_valid_q | frame_ovf_q) begin
                wr_ptr_d = commit_ptr_q;
                bad_d    = bad_q + 16'd1;
                if (hold_valid_q & ~kill & full) begin
                    overflow_d = 1'b1;
                end
            end
            hold_valid_d = 1'b0;
            frame_ovf_d  = 1'b0;
            if (axiiv) begin
                hold_d       = axiid;
                hold_valid_d = 1'b1;
            end
        end else if (axiiv) begin
            if (hold_valid_q) begin
                if (full) begin
                    frame_ovf_d = 1'b1;
                    overflow_d  = 1'b1;
                end else begin
                    we       = 1'b1;
                    wdata    = {1'b0, hold_q};
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end
            hold_d       = axiid;
            hold_valid_d = 1'b1;
        end
    end

    assign avail  = (rd_ptr_q != commit_ptr_q);
    assign pop    = o_v_q & axiir;
    assign rd_en  = avail & ~(f_v_q & o_v_q & ~pop);
    assign o_load = f_v_q & (~o_v_q | pop);

    // read side: two-slot pipeline keeps full rate under backpressure
    always_comb begin
        rd_ptr_d = rd_ptr_q + (rd_en ? PTR_ONE : '0);
        if (o_load) begin
            o_v_d = 1'b1;
        end else if (pop) begin
            o_v_d = 1'b0;
        end else begin
            o_v_d = o_v_q;
        end
        if (rd_en) begin
            f_v_d = 1'b1;
        end else if (o_load) begin
            f_v_d = 1'b0;
        end else begin
            f_v_d = f_v_q;
        end
    end

    // buffer RAM: write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
        if (rd_en) begin
            f_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            frame_ovf_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            ok_q         <= '0;
            bad_q        <= '0;
            f_v_q        <= 1'b0;
            o_v_q        <= 1'b0;
            o_q          <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            frame_ovf_q  <= frame_ovf_d;
            done_q       <= done;
            overflow_q   <= overflow_d;
            ok_q         <= ok_d;
            bad_q        <= bad_d;
            f_v_q        <= f_v_d;
            o_v_q        <= o_v_d;
            if (o_load) begin
                o_q <= f_q;
            end
        end
    end

    assign axiov      = o_v_q;
    assign axiod      = o_q[WIDTH-1:0];
    assign axiol      = o_q[WIDTH];
    assign frames_ok  = ok_q;
    assign frames_bad = bad_q;
    assign overflow   = overflow_q;

endmodule
